// File: rtl/reg_share_arbiter_pkg.sv
// reg_share_pkg: shared types and width helpers for the register-sharing arbiter
package reg_share_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;
  function automatic int id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int h);
    return (h > 1) ? $clog2(h + 1) : 1;
  endfunction
endpackage

// File: rtl/reg_share_arbiter_if.sv
// reg_share_arbiter_if: requester-side bus of the shared register arbiter
interface reg_share_arbiter_if
  import reg_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0] gnt;
  logic [DATA_W-1:0] reg_q;
  logic [id_w(NUM_REQ)-1:0] owner;
  logic valid_q;
  logic busy;
  modport master(output req, req_data, input gnt, reg_q, owner, valid_q, busy);
  modport slave(input req, req_data, output gnt, reg_q, owner, valid_q, busy);
endinterface

// File: rtl/reg_share_arbiter_pick.sv
// rr_priority_pick: round-robin winner search starting just after the last grantee
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic               any_req,
  output logic [ID_W-1:0]    winner
);
  int idx;
  // scan from farthest to nearest so the slot right after last wins
  always_comb begin
    any_req = |req;
    winner = '0;
    idx = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (req[idx]) winner = ID_W'(idx);
    end
  end
endmodule

// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: round-robin arbiter writing one shared register with grant pulse and guard hold
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 4,
  parameter int HOLD_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  reg_share_arbiter_if.slave bus
);
  localparam int ID_W = id_w(NUM_REQ);
  localparam int CNT_W = cnt_w(HOLD_CYCLES);
  localparam int HOLD_N = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [ID_W-1:0] last, win, owner;
  logic [DATA_W-1:0] reg_q;
  logic any_req, valid_q;
  rr_priority_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req(bus.req),
    .last(last),
    .any_req(any_req),
    .winner(win)
  );
  // state, guard counter and the shared register; only the arbitration edge writes reg_q
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      last <= ID_W'(NUM_REQ - 1);
      reg_q <= '0;
      owner <= '0;
      valid_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (state == IDLE && any_req) begin
        reg_q <= bus.req_data[win*DATA_W +: DATA_W];
        owner <= win;
        last <= win;
        valid_q <= 1'b1;
      end
    end
  end
  // next state: arbitrate, pulse grant, then count out the guard interval
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    unique case (state)
      IDLE: state_nx = any_req ? GRANT : IDLE;
      GRANT: begin
        state_nx = (HOLD_CYCLES == 0) ? IDLE : HOLD;
        cnt_nx = CNT_W'(HOLD_N);
      end
      HOLD: begin
        state_nx = (cnt == '0) ? IDLE : HOLD;
        cnt_nx = (cnt == '0) ? cnt : cnt - 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign bus.gnt = (state == GRANT) ? (NUM_REQ'(1) << owner) : '0;
  assign bus.busy = (state != IDLE);
  assign bus.reg_q = reg_q;
  assign bus.owner = owner;
  assign bus.valid_q = valid_q;
endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
- Round-robin arbiter that shares one DATA_W-bit storage register among NUM_REQ requesters.
- Each winning requester's data is written into the register, acknowledged with a one-cycle grant pulse, then held for a fixed guard interval before the next arbitration.
- Sits in front of the shared 4-bit state register; it replaces direct single-writer data_in driving.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_W, 4, width of the shared register and of each requester's data.
- HOLD_CYCLES, 2, guard cycles after a grant before re-arbitration (0 allowed).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester write request, level, held until gnt seen
- req_data  in  NUM_REQ*DATA_W  requester i's data in bits [i*DATA_W +: DATA_W]
- gnt  out  NUM_REQ  one-hot grant pulse, one cycle
- reg_q  out  DATA_W  shared register contents
- owner  out  $clog2(NUM_REQ)  index of last writer
- valid_q  out  1  high once reg_q has been written since reset
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values, all synchronous: state=IDLE, reg_q=0, owner=0, gnt=0, valid_q=0, busy=0, hold counter=0, rr pointer last=NUM_REQ-1 (req0 has top priority first).
- States:
  - IDLE: arbitrate.
  - GRANT: pulse grant.
  - HOLD: guard interval.
- IDLE, req==0: stay in IDLE; no output changes.
- IDLE, req!=0 (edge T):
  - Winner w is the first set bit searching last+1, last+2, ..., last, with wrap-around modulo NUM_REQ.
  - At edge T: reg_q<=req_data[w], owner<=w, last<=w, valid_q<=1, state<=GRANT.
- GRANT (cycle T+1):
  - gnt = onehot(owner); Moore output, decoded from state, no combinational path from req.
  - busy=1.
  - Next state: HOLD with counter=HOLD_CYCLES-1; if HOLD_CYCLES==0, go directly to IDLE.
- HOLD:
  - busy=1, gnt=0, req ignored.
  - When counter==0, go to IDLE; otherwise decrement.
- Timing:
  - Grant latency: 1 cycle after the arbitration cycle.
  - Minimum spacing between grants: 2+HOLD_CYCLES cycles.
- Requester contract: drop req the cycle after seeing gnt. A req still high on return to IDLE is treated as a new request.
- Withdrawal: a req deasserted before the IDLE arbitration edge is never granted; no state change.
- reg_q changes only at the IDLE->GRANT edge; it is stable through GRANT and HOLD.
- Simultaneous requests resolve purely by the rr pointer; no starvation. With all requests persistently high, each requester is served once per NUM_REQ grants.
- Reset mid-operation:
  - Reset during GRANT: gnt is still high in that cycle; at the edge everything returns to reset values, including reg_q=0 and valid_q=0.
  - Reset during HOLD: IDLE on the next cycle, counter cleared.
  - Requesters treat reset as an abort.
- reset has priority over every transition.
- No X on outputs after the first reset edge.

Decomposition:
- Package reg_share_pkg:
  - state enum {IDLE, GRANT, HOLD}.
  - Localparam width helpers: ID_W=$clog2(NUM_REQ), CNT_W=$clog2(HOLD_CYCLES+1), minimum 1.
- Sub-module rr_priority_pick: combinational.
  - Inputs: req vector and last pointer.
  - Outputs: any_req and winner index.
- FSM, counter and storage register live in the top.

Test Plan:
- Reset, then req=4'b0100, data[2]=4'hA -> gnt=4'b0100 for exactly one cycle, one cycle after the arbitration edge; reg_q=4'hA, owner=2, valid_q=1, busy high for 1+HOLD_CYCLES=3 cycles.
- After reset, req=4'b1111 held and each dropped after its gnt, data[i]=i+5 -> grant order 0,1,2,3, grants 4 cycles apart, reg_q sequence 5,6,7,8.
- req0 and req3 persistently high (re-raised after each gnt) -> grants alternate 0,3,0,3; no starvation.
- req1 rises during HOLD -> no gnt during HOLD; gnt=4'b0010 one cycle after the return to IDLE; reg_q unchanged until that arbitration edge.
- reset asserted in the 2nd HOLD cycle -> next cycle state IDLE, reg_q=0, valid_q=0, owner=0, gnt=0; a following req0 is granted normally.
- HOLD_CYCLES=0 build, req=4'b0011 held -> grants 0 then 1, two cycles apart; a req pulsed for one cycle while in GRANT is never granted.
